// File: rtl/clk_divider.sv
// clk_divider: fixed-ratio clock divider with an exact 50% duty cycle.
//   DIV   - division ratio, 2..65535
//   CW    - counter width, 2**CW must cover DIV
// Ports:
//   clk     - reference clock
//   reset   - asynchronous active-low reset
//   clk_out - divided clock, f(clk)/DIV
// Even DIV drives clk_out straight from a posedge flop. Odd DIV ORs that flop
// with a negedge copy of itself, stretching the high phase by half a period.
module clk_divider #(
    parameter int unsigned DIV = 10,
    parameter int unsigned CW  = 16
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out
);

    // Posedge flop is high for count values HI..DIV-1.
    localparam int unsigned HI  = (DIV + 1) / 2;
    localparam bit          ODD = (DIV % 2) == 1;

    // Elaboration-time parameter checks.
    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("clk_divider: DIV=%0d outside 2..65535", DIV);
    end
    if ((64'd1 << CW) < 64'(DIV)) begin : g_bad_cw
        $error("clk_divider: CW=%0d too narrow for DIV=%0d", CW, DIV);
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          pos_d;
    logic          pos_q;

    // Next count with wrap after DIV-1, and the posedge phase decode.
    always_comb begin
        cnt_next = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_next = '0;
        end
        pos_d = (cnt_next >= CW'(HI));
    end

    // Edge counter and posedge phase flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            pos_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            pos_q <= pos_d;
        end
    end

    if (ODD) begin : g_odd
        logic neg_q;

        // Half-period delayed copy; pos_q falls while neg_q is still high,
        // so the OR below never glitches.
        always_ff @(negedge clk or negedge reset) begin
            if (!reset) begin
                neg_q <= 1'b0;
            end else begin
                neg_q <= pos_q;
            end
        end

        assign clk_out = pos_q | neg_q;
    end else begin : g_even
        assign clk_out = pos_q;
    end

endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: checks seven divider instances (DIV = 10,2,3,4,7,16,255)
// sharing one clock and reset, sampled 1 ns after every clk edge.
module tb_clk_divider;

    localparam int NDUT = 7;
    localparam int MAXK = 5000;

    function automatic int unsigned div_of(input int idx);
        case (idx)
            0:       return 10;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 7;
            5:       return 16;
            default: return 255;
        endcase
    endfunction

    logic            clk;
    logic            reset;
    logic [NDUT-1:0] outs;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        clk_divider #(.DIV(div_of(g)), .CW(16)) u_dut (
            .clk     (clk),
            .reset   (reset),
            .clk_out (outs[g])
        );
    end

    // Posedges at 10, 20, 30 ... ns; negedges at 5, 15, 25 ... ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Expected output from the rise/fall edge rules: k = edges since release,
    // half = 0 sampled after the posedge, 1 after the following negedge.
    function automatic logic exp_out(input int d, input int k, input bit half);
        int m;
        if (k < 1) return 1'b0;
        m = k % d;
        if (d % 2 == 0) return (m >= d / 2);
        return (m >= (d + 1) / 2) || (!half && m == 0);
    endfunction

    typedef struct {
        int   dut;
        int   k;
        bit   half;
        logic exp;
    } vec_t;

    vec_t            vecs[$];
    logic [NDUT-1:0] rec_p [0:MAXK];
    logic [NDUT-1:0] rec_n [0:MAXK];
    int              checks;
    int              errors;
    int              k;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add_vec(input int dut, input int kk, input bit h, input logic e);
        vec_t v;
        v.dut  = dut;
        v.k    = kk;
        v.half = h;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic hold_bad [NDUT];
        logic act;

        // Hand-computed points: {dut index, edge k, half, expected clk_out}.
        add_vec(0,   4, 0, 1'b0); add_vec(0,   5, 0, 1'b1); add_vec(0,   9, 1, 1'b1);
        add_vec(0,  10, 0, 1'b0); add_vec(0,  15, 0, 1'b1); add_vec(0,  20, 0, 1'b0);
        add_vec(1,   1, 0, 1'b1); add_vec(1,   1, 1, 1'b1); add_vec(1,   2, 0, 1'b0);
        add_vec(1,   3, 0, 1'b1);
        add_vec(2,   1, 1, 1'b0); add_vec(2,   2, 0, 1'b1); add_vec(2,   2, 1, 1'b1);
        add_vec(2,   3, 0, 1'b1); add_vec(2,   3, 1, 1'b0); add_vec(2,   4, 0, 1'b0);
        add_vec(2,   5, 0, 1'b1); add_vec(2,   6, 0, 1'b1); add_vec(2,   6, 1, 1'b0);
        add_vec(3,   1, 0, 1'b0); add_vec(3,   2, 0, 1'b1); add_vec(3,   3, 1, 1'b1);
        add_vec(3,   4, 0, 1'b0);
        add_vec(4,   3, 1, 1'b0); add_vec(4,   4, 0, 1'b1); add_vec(4,   6, 1, 1'b1);
        add_vec(4,   7, 0, 1'b1); add_vec(4,   7, 1, 1'b0); add_vec(4,  11, 0, 1'b1);
        add_vec(5,   7, 0, 1'b0); add_vec(5,   8, 0, 1'b1); add_vec(5,  15, 1, 1'b1);
        add_vec(5,  16, 0, 1'b0);
        add_vec(6, 127, 1, 1'b0); add_vec(6, 128, 0, 1'b1); add_vec(6, 254, 1, 1'b1);
        add_vec(6, 255, 0, 1'b1); add_vec(6, 255, 1, 1'b0); add_vec(6, 383, 0, 1'b1);

        checks = 0;
        errors = 0;
        k      = 0;
        reset  = 1'b0;

        // Outputs are a defined 0 right from the first reset assertion.
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_t0 div%0d", div_of(i)), outs[i], 1'b0);
        end

        // Reset held for 100 clk cycles: every output stays 0 at every edge.
        for (int i = 0; i < NDUT; i++) hold_bad[i] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) if (outs[i] !== 1'b0) hold_bad[i] = 1'b1;
            @(negedge clk); #1;
            for (int i = 0; i < NDUT; i++) if (outs[i] !== 1'b0) hold_bad[i] = 1'b1;
        end
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_hold div%0d", div_of(i)), hold_bad[i], 1'b0);
        end

        // Release on a negedge, then record MAXK clk periods.
        @(negedge clk);
        reset = 1'b1;
        for (int kk = 1; kk <= MAXK; kk++) begin
            @(posedge clk); #1;
            k = kk;
            rec_p[kk] = outs;
            @(negedge clk); #1;
            rec_n[kk] = outs;
        end

        // Directed table.
        foreach (vecs[i]) begin
            act = vecs[i].half ? rec_n[vecs[i].k][vecs[i].dut] : rec_p[vecs[i].k][vecs[i].dut];
            check($sformatf("vec%0d div%0d k%0d h%0d", i, div_of(vecs[i].dut), vecs[i].k, vecs[i].half),
                  act, vecs[i].exp);
        end

        // Whole-run sweep per instance: period DIV, 50% duty, no wrap artefacts.
        for (int i = 0; i < NDUT; i++) begin
            int   bad_k;
            bit   bad_h;
            logic bad_act;
            bad_k   = 0;
            bad_h   = 1'b0;
            bad_act = 1'b0;
            for (int kk = 1; kk <= MAXK && bad_k == 0; kk++) begin
                if (rec_p[kk][i] !== exp_out(int'(div_of(i)), kk, 1'b0)) begin
                    bad_k = kk; bad_h = 1'b0; bad_act = rec_p[kk][i];
                end else if (rec_n[kk][i] !== exp_out(int'(div_of(i)), kk, 1'b1)) begin
                    bad_k = kk; bad_h = 1'b1; bad_act = rec_n[kk][i];
                end
            end
            if (bad_k == 0) begin
                check($sformatf("sweep div%0d", div_of(i)), rec_p[MAXK][i],
                      exp_out(int'(div_of(i)), MAXK, 1'b0));
            end else begin
                check($sformatf("sweep div%0d k%0d h%0d", div_of(i), bad_k, bad_h), bad_act,
                      exp_out(int'(div_of(i)), bad_k, bad_h));
            end
        end

        // Mid-high reset on DIV=10: advance to count 7 (inside the high phase).
        while (k % 10 != 7) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("pre_reset_high div10", outs[0], 1'b1);
        reset = 1'b0;
        #1;
        check("reset_truncate div10", outs[0], 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("reset_mid_hold%0d", c), (outs == '0), 1'b1);
        end
        @(negedge clk);
        reset = 1'b1;

        // Restart identical to power-up: DIV=10 first rises at edge 5.
        for (int kk = 1; kk <= 6; kk++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("restart div%0d k%0d", div_of(i), kk), outs[i],
                      exp_out(int'(div_of(i)), kk, 1'b0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
